// File: rtl/ac_op_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : ac_pkg                                                 |
// | Shared opcode encodings, select-bit indices and sequencer states |
// | for the accumulator output-mux controller.                       |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
package ac_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_NOT   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_SUM   = 3'd4;
  localparam logic [2:0] OP_SHIFT = 3'd5;

  typedef enum logic [2:0] {
    AC_AND   = OP_AND,
    AC_NOT   = OP_NOT,
    AC_OR    = OP_OR,
    AC_XOR   = OP_XOR,
    AC_SUM   = OP_SUM,
    AC_SHIFT = OP_SHIFT
  } ac_op_t;

  // Bit positions inside the one-hot select bus
  localparam int SEL_AND   = 0;
  localparam int SEL_NOT   = 1;
  localparam int SEL_OR    = 2;
  localparam int SEL_XOR   = 3;
  localparam int SEL_SUM   = 4;
  localparam int SEL_SHIFT = 5;
  localparam int SEL_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RESP   = 2'd3
  } ac_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ac_op_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : ac_op_sequencer_if                                   |
// | Request/response handshake plus the mux select/result bus of the |
// | accumulator sequencer. master = requester + mux, slave = DUT.    |
// | Rev       : 1.0                                                  |
// +------------------------------------------------------------------+
interface ac_op_sequencer_if #(
  parameter int WIDTH = 16
);
  import ac_pkg::*;

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [3:0]       shamt;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] mux_res;
  logic [WIDTH-1:0] ac;
  logic             ac_load;
  logic             resp_valid;
  logic             resp_err;
  logic             resp_ready;

  modport master (
    output op_valid, opcode, shamt, mux_res, resp_ready,
    input  op_ready, sel, ac, ac_load, resp_valid, resp_err
  );

  modport slave (
    input  op_valid, opcode, shamt, mux_res, resp_ready,
    output op_ready, sel, ac, ac_load, resp_valid, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/ac_op_sequencer_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : ac_op_decode                                            |
// | Combinational opcode to one-hot mux select, with illegal flag.   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module ac_op_decode
  import ac_pkg::*;
(
  input  logic [2:0]       opcode,
  output logic [SEL_W-1:0] sel,
  output logic             illegal
);

  // One select bit per legal opcode; codes 6 and 7 select nothing
  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    case (opcode)
      AC_AND:   sel[SEL_AND]   = 1'b1;
      AC_NOT:   sel[SEL_NOT]   = 1'b1;
      AC_OR:    sel[SEL_OR]    = 1'b1;
      AC_XOR:   sel[SEL_XOR]   = 1'b1;
      AC_SUM:   sel[SEL_SUM]   = 1'b1;
      AC_SHIFT: sel[SEL_SHIFT] = 1'b1;
      default:  illegal        = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ac_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : ac_op_sequencer                                         |
// | Multi-cycle controller for the AC output mux: holds a one-hot    |
// | select for a settle window, then loads the mux result into AC.   |
// | Shift-by-N runs as N single-bit passes.                          |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module ac_op_sequencer
  import ac_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2   // legal 1..15
) (
  input  logic             clk,
  input  logic             reset,
  ac_op_sequencer_if.slave bus
);

  // Settle counter counts down to zero, so it is reloaded with S-1
  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  ac_seq_state_t    state;
  logic [2:0]       op_q;
  logic [3:0]       settle_cnt;
  logic [4:0]       pass_cnt;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] ac_q;
  logic             ac_load_q;
  logic             op_ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;

  logic [2:0]       dec_opcode;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_illegal;
  logic             zero_shift;
  logic [4:0]       pass_init;

  // While idle decode the incoming request; afterwards the latched opcode
  assign dec_opcode = (state == ST_IDLE) ? bus.opcode : op_q;

  ac_op_decode u_decode (
    .opcode  (dec_opcode),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign zero_shift = (bus.opcode == OP_SHIFT) && (bus.shamt == 4'd0);
  // 5-bit pass count so that shamt=15 never wraps
  assign pass_init  = (bus.opcode == OP_SHIFT) ? {1'b0, bus.shamt} : 5'd1;

  // Sequencer FSM with counters, AC register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= OP_AND;
      settle_cnt   <= 4'd0;
      pass_cnt     <= 5'd0;
      sel_q        <= '0;
      ac_q         <= '0;
      ac_load_q    <= 1'b0;
      op_ready_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      ac_load_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            op_q       <= bus.opcode;
            op_ready_q <= 1'b0;
            if (dec_illegal || zero_shift) begin
              // Nothing to compute: answer straight away, select stays 0
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= dec_illegal;
            end else begin
              state      <= ST_SETTLE;
              sel_q      <= dec_sel;
              settle_cnt <= SETTLE_RELOAD;
              pass_cnt   <= pass_init;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state     <= ST_LOAD;
            ac_load_q <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_LOAD: begin
          ac_q     <= bus.mux_res;
          pass_cnt <= pass_cnt - 5'd1;
          if (pass_cnt == 5'd1) begin
            state        <= ST_RESP;
            sel_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
          end else begin
            // Another shift pass: select is unchanged, restart the window
            state      <= ST_SETTLE;
            sel_q      <= dec_sel;
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            op_ready_q   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready   = op_ready_q;
  assign bus.sel        = sel_q;
  assign bus.ac         = ac_q;
  assign bus.ac_load    = ac_load_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ac_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_ac_op_sequencer                                      |
// | Directed bench for ac_op_sequencer with a cycle-level reference  |
// | model derived from the timing rules, plus literal expectations.  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ac_op_sequencer;
  import ac_pkg::*;

  localparam int W      = 16;
  localparam int S      = 2;
  localparam int S2     = 15;
  localparam int BUDGET = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] operand;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ac_op_sequencer_if #(.WIDTH(W)) b  ();
  ac_op_sequencer_if #(.WIDTH(W)) b2 ();

  ac_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  ac_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S2)) u_dut15 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  // Gate-level mux stand-in: result chosen by the DUT's select lines
  always_comb begin
    case (b.sel)
      6'b000001: b.mux_res = b.ac & operand;
      6'b000010: b.mux_res = ~b.ac;
      6'b000100: b.mux_res = b.ac | operand;
      6'b001000: b.mux_res = b.ac ^ operand;
      6'b010000: b.mux_res = b.ac + operand;
      6'b100000: b.mux_res = b.ac << 1;
      default:   b.mux_res = '0;
    endcase
  end

  // Shift-in-a-one mux for the long-settle instance
  always_comb b2.mux_res = (b2.sel == 6'b100000) ? {b2.ac[W-2:0], 1'b1} : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] x);
    case (op)
      3'd0:    return a & x;
      3'd1:    return ~a;
      3'd2:    return a | x;
      3'd3:    return a ^ x;
      3'd4:    return a + x;
      3'd5:    return a << 1;
      default: return a;
    endcase
  endfunction

  // Reference model: position within an operation measured in cycles
  bit         m_idle = 1'b1;
  int         m_d    = 0;
  int         m_k    = 0;
  bit         m_short = 1'b0;
  bit         m_err  = 1'b0;
  logic [2:0] m_op   = 3'd0;
  logic [W-1:0] m_ac = '0;

  always @(negedge clk) begin
    logic [5:0] one;
    logic [5:0] e_sel;
    bit   in_resp, e_ld;
    int   period;
    one    = 6'd1;
    period = S + 1;
    if (reset) begin
      m_idle = 1'b1;
      m_ac   = '0;
    end
    in_resp = !m_idle && (m_short || (m_d > m_k * period));
    e_ld    = !m_idle && !in_resp && ((m_d % period) == 0);
    e_sel   = (!m_idle && !in_resp) ? (one << m_op) : 6'd0;
    chk("m_op_ready",   32'(b.op_ready),   32'(m_idle));
    chk("m_sel",        32'(b.sel),        32'(e_sel));
    chk("m_ac_load",    32'(b.ac_load),    32'(e_ld));
    chk("m_resp_valid", 32'(b.resp_valid), 32'(in_resp));
    chk("m_resp_err",   32'(b.resp_err),   32'(in_resp && m_err));
    chk("m_ac",         32'(b.ac),         32'(m_ac));
    if (!reset) begin
      if (m_idle) begin
        if (b.op_valid) begin
          m_op    = b.opcode;
          m_err   = (b.opcode > 3'd5);
          m_k     = (b.opcode == 3'd5) ? int'(b.shamt) : 1;
          m_short = m_err || (m_k == 0);
          m_idle  = 1'b0;
          m_d     = 1;
        end
      end else if (in_resp) begin
        if (b.resp_ready) m_idle = 1'b1;
      end else begin
        if (e_ld) m_ac = alu(m_op, m_ac, operand);
        m_d++;
      end
    end
  end

  // Issue one op, then observe until resp_valid; cycle 1 = first after accept
  task automatic run_op(input logic [2:0] op, input logic [3:0] sh, output int resp_cyc,
                        output int first_ld, output int last_ld, output int nld,
                        output logic [5:0] sel_or);
    int n;
    b.op_valid = 1'b1;
    b.opcode   = op;
    b.shamt    = sh;
    n = 0;
    while (!b.op_ready && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    chk("accept", 32'(b.op_ready), 32'd1);
    @(posedge clk); #1;
    b.op_valid = 1'b0;
    resp_cyc = 1; first_ld = 0; last_ld = 0; nld = 0; sel_or = '0;
    while (!b.resp_valid && resp_cyc < BUDGET) begin
      sel_or |= b.sel;
      if (b.ac_load) begin
        nld++;
        if (first_ld == 0) first_ld = resp_cyc;
        last_ld = resp_cyc;
      end
      @(posedge clk); #1; resp_cyc++;
    end
  endtask

  task automatic consume();
    b.resp_ready = 1'b1;
    @(posedge clk); #1;
    b.resp_ready = 1'b0;
  endtask

  initial begin
    int rc, fl, ll, nl, cyc;
    logic [5:0] so;
    bit seen;
    b.op_valid = 0; b.opcode = 0; b.shamt = 0; b.resp_ready = 0;
    b2.op_valid = 0; b2.opcode = 0; b2.shamt = 0; b2.resp_ready = 0;
    operand = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_ready",   32'(b.op_ready),   32'd1);
    chk("rst_sel",        32'(b.sel),        32'd0);
    chk("rst_ac",         32'(b.ac),         32'd0);
    chk("rst_resp_valid", 32'(b.resp_valid), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // OR, mux returns 0x00F0
    operand = 16'h00F0;
    run_op(3'd2, 4'd0, rc, fl, ll, nl, so);
    chk("or_resp_cycle", 32'(rc), 32'd4);
    chk("or_load_cycle", 32'(fl), 32'd3);
    chk("or_loads",      32'(nl), 32'd1);
    chk("or_sel",        32'(so), 32'(6'b000100));
    chk("or_ac",         32'(b.ac), 32'h00F0);
    chk("or_err",        32'(b.resp_err), 32'd0);
    consume();

    // XOR brings AC to 0x0001
    operand = 16'h00F1;
    run_op(3'd3, 4'd0, rc, fl, ll, nl, so);
    chk("xor_ac", 32'(b.ac), 32'h0001);
    consume();

    // Shift by 3
    run_op(3'd5, 4'd3, rc, fl, ll, nl, so);
    chk("sh3_loads",      32'(nl), 32'd3);
    chk("sh3_first",      32'(fl), 32'd3);
    chk("sh3_last",       32'(ll), 32'd9);
    chk("sh3_resp_cycle", 32'(rc), 32'd10);
    chk("sh3_ac",         32'(b.ac), 32'h0008);
    chk("sh3_sel",        32'(so), 32'(6'b100000));
    consume();

    // Shift by 0, then illegal opcode 7
    run_op(3'd5, 4'd0, rc, fl, ll, nl, so);
    chk("sh0_resp_cycle", 32'(rc), 32'd1);
    chk("sh0_sel",        32'(so), 32'd0);
    chk("sh0_err",        32'(b.resp_err), 32'd0);
    chk("sh0_ac",         32'(b.ac), 32'h0008);
    consume();
    run_op(3'd7, 4'd2, rc, fl, ll, nl, so);
    chk("ill_resp_cycle", 32'(rc), 32'd1);
    chk("ill_loads",      32'(nl), 32'd0);
    chk("ill_err",        32'(b.resp_err), 32'd1);
    chk("ill_ac",         32'(b.ac), 32'h0008);
    consume();

    // AND and SUM patterns
    operand = 16'h000C;
    run_op(3'd0, 4'd0, rc, fl, ll, nl, so);
    chk("and_ac", 32'(b.ac), 32'h0008);
    consume();
    operand = 16'h0007;
    run_op(3'd4, 4'd0, rc, fl, ll, nl, so);
    chk("sum_ac", 32'(b.ac), 32'h000F);
    consume();

    // Backpressure: NOT, response held 5 cycles with a second request pending
    run_op(3'd1, 4'd0, rc, fl, ll, nl, so);
    chk("not_ac", 32'(b.ac), 32'hFFF0);
    operand    = 16'h0011;
    b.op_valid = 1'b1;
    b.opcode   = 3'd4;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(b.resp_valid), 32'd1);
      chk("bp_op_ready",   32'(b.op_ready),   32'd0);
      @(posedge clk); #1;
    end
    b.resp_ready = 1'b1;
    @(posedge clk); #1;
    b.resp_ready = 1'b0;
    chk("bp_idle_ready", 32'(b.op_ready), 32'd1);
    chk("bp_idle_sel",   32'(b.sel),      32'd0);
    @(posedge clk); #1;
    b.op_valid = 1'b0;
    chk("bp_accepted_sel", 32'(b.sel), 32'(6'b010000));
    cyc = 1;
    while (!b.resp_valid && cyc < BUDGET) begin
      @(posedge clk); #1; cyc++;
    end
    chk("bp_sum_cycle", 32'(cyc), 32'd4);
    chk("bp_sum_ac",    32'(b.ac), 32'h0001);
    consume();

    // Reset during the 2nd pass of a 4-pass shift
    b.op_valid = 1'b1;
    b.opcode   = 3'd5;
    b.shamt    = 4'd4;
    @(posedge clk); #1;
    b.op_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_ac_before", 32'(b.ac), 32'h0002);
    reset = 1'b1;
    #1;
    chk("mid_op_ready",   32'(b.op_ready),   32'd1);
    chk("mid_sel",        32'(b.sel),        32'd0);
    chk("mid_ac",         32'(b.ac),         32'd0);
    chk("mid_ac_load",    32'(b.ac_load),    32'd0);
    chk("mid_resp_valid", 32'(b.resp_valid), 32'd0);
    chk("mid_resp_err",   32'(b.resp_err),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= b.resp_valid;
    end
    chk("mid_no_resp", 32'(seen), 32'd0);

    // Longest settle with the longest shift on the S=15 instance
    b2.op_valid = 1'b1;
    b2.opcode   = 3'd5;
    b2.shamt    = 4'd15;
    chk("max_ready", 32'(b2.op_ready), 32'd1);
    @(posedge clk); #1;
    b2.op_valid = 1'b0;
    cyc = 1; nl = 0;
    while (!b2.resp_valid && cyc < BUDGET) begin
      if (b2.ac_load) nl++;
      @(posedge clk); #1; cyc++;
    end
    chk("max_loads",      32'(nl), 32'd15);
    chk("max_resp_cycle", 32'(cyc), 32'd241);
    chk("max_ac",         32'(b2.ac), 32'h7FFF);
    chk("max_err",        32'(b2.resp_err), 32'd0);
    b2.resp_ready = 1'b1;
    @(posedge clk); #1;
    b2.resp_ready = 1'b0;
    chk("max_back_idle", 32'(b2.op_ready), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ac_op_sequencer.md
# ac_op_sequencer

Multi-cycle controller for the accumulator (AC) output mux. It accepts one ALU operation at a time over a valid/ready handshake and drives the mux's one-hot select lines (`andbit`, `notbit`, `orbit`, `xorbit`, `sumbit`, `shiftbit`). It holds each select stable for a programmable settle window that covers the gate-level propagation delay, then loads the mux result into the AC register it owns. Shift-by-N is performed as N successive 1-bit shift passes through the same mux.

## Interface
- `WIDTH`, 16: AC and mux result width.
- `SETTLE_CYCLES`, 2: cycles the select is held before the load; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `op_valid` input 1: operation request.
- `op_ready` output 1: high only in IDLE.
- `opcode` input 3: 0 AND, 1 NOT, 2 OR, 3 XOR, 4 SUM, 5 SHIFT, 6–7 illegal.
- `shamt` input 4: shift pass count; used only when `opcode`=5.
- `sel` output 6: one-hot {shiftbit, sumbit, xorbit, orbit, notbit, andbit}, bit 0 = andbit.
- `mux_res` input WIDTH: `resbit` vector returned from the mux.
- `ac` output WIDTH: AC register; also feeds the datapath operands.
- `ac_load` output 1: one-cycle pulse on each AC update.
- `resp_valid` output 1: operation complete.
- `resp_err` output 1: qualified by `resp_valid`; set for an illegal opcode.
- `resp_ready` input 1: response consumed.

## Operation
- **States:** IDLE, SETTLE, LOAD, RESP.
- **IDLE:**
  - `op_ready`=1 and `sel`=0.
  - On `op_valid`: latch `opcode`, `shamt`, and the error flag.
  - Illegal opcode, or SHIFT with `shamt`=0: go to RESP. AC is unchanged and `sel` stays 0. `resp_err`=1 for the illegal opcode only.
  - Otherwise: go to SETTLE. Load the settle counter with `SETTLE_CYCLES`-1 and load the pass counter with `shamt`, or 1 for a non-shift op.
- **SETTLE:**
  - `sel` = one-hot of the latched opcode.
  - Decrement the counter each cycle.
  - At 0, go to LOAD.
- **LOAD:**
  - `sel` held.
  - `ac_load`=1 and `ac` <= `mux_res`.
  - Decrement the pass counter.
  - If the pass count is now 0, go to RESP. Otherwise go back to SETTLE and reload the settle counter.
- **RESP:**
  - `sel`=0 and `resp_valid`=1.
  - On `resp_ready`, return to IDLE.
- `sel` is never multi-hot, and it changes only on the SETTLE entry edge and the RESP/IDLE entry edge.
- The pass counter is 5 bits wide, so `shamt`=15 runs 15 passes without wrap. The settle counter is 4 bits wide.
- `op_valid` while busy is ignored. The requester holds it until `op_ready`.

## Timing
- **Reset values:**
  - state IDLE.
  - `op_ready`=1 and `sel`=0.
  - `ac`=0 and `ac_load`=0.
  - `resp_valid`=0 and `resp_err`=0.
- **Asserting `reset` mid-operation:** immediately forces all of the above. The operation is discarded with no response.
- **Single-pass latency (accept at edge 0):**
  - `sel` valid on cycles 1..S.
  - `ac_load` on cycle S+1.
  - `resp_valid` from cycle S+2.
  - Here S = `SETTLE_CYCLES`.
- **SHIFT with `shamt`=k:**
  - `ac_load` pulses at cycles j·(S+1) for j = 1..k.
  - `resp_valid` at k·(S+1)+1.
- **Illegal opcode or `shamt`=0:** `resp_valid` on cycle 1.
- **Back-to-back:** if `resp_ready`=1 while `resp_valid`=1, the next cycle is IDLE, and a new op can be accepted that cycle. The minimum spacing between accepts is S+3 cycles.
- **`ac` visibility:** `ac` is registered; the new value is visible the cycle after `ac_load`. The mux operand path sees the updated `ac` for the next shift pass.

## Structure
- Shared package `ac_pkg`:
  - opcode enum `ac_op_t` (AND..SHIFT) with localparam encodings.
  - `sel` bit-index constants.
  - state enum `ac_seq_state_t`.
- One natural sub-module, `ac_op_decode`: combinational opcode → one-hot `sel`, plus an illegal flag.
- The FSM, both counters and the AC register stay in `ac_op_sequencer`.

## Test plan
- **Reset then single op:** reset, then OR with S=2 and bench mux returning 0x00F0. Required: `sel`=6'b000100 on cycles 1–2, `ac_load` on cycle 3, `ac`=0x00F0 and `resp_valid` on cycle 4, `resp_err`=0.
- **Shift loop:** AC=0x0001, SHIFT with `shamt`=3, bench mux modelling shift-left of `ac`. Required: 3 `ac_load` pulses 3 cycles apart, final `ac`=0x0008, `sel`=6'b100000 throughout the busy period.
- **Zero and illegal:** SHIFT with `shamt`=0, then opcode 7. Required: each gives `resp_valid` on cycle 1, `ac` unchanged, `sel` never nonzero; `resp_err`=0 for the first and 1 for the second.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles. Required: `resp_valid` stays high, `op_ready`=0, and a second `op_valid` is not accepted until one cycle after `resp_ready`.
- **Reset mid-shift:** assert `reset` during the 2nd pass of `shamt`=4. Required: all outputs immediately at reset values and no `resp_valid`.
- **Max settle:** S=15 with `shamt`=15. Required: exactly 15 loads and `resp_valid` at cycle 241.
